// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer and its program memory.
package seq_pkg;

  localparam int unsigned PROG_DEPTH = 16;
  localparam int unsigned PC_W       = 4;
  localparam int unsigned WDOG_W     = 4;
  localparam int unsigned WDOG_MAX   = 15;
  localparam int unsigned INSTR_W    = 16;
  localparam int unsigned LEN_W      = 5;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    FIN,
    ERR
  } seq_state_e;

  // Requested lengths above the memory depth run the whole memory once.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len > LEN_W'(PROG_DEPTH)) begin
      return LEN_W'(PROG_DEPTH);
    end
    return len;
  endfunction

endpackage

// File: rtl/prog_mem.sv
// 16x16 program memory: synchronous write, asynchronous read, cleared by reset.
module prog_mem
  import seq_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [PC_W-1:0]    waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [PC_W-1:0]    raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem_q [PROG_DEPTH];
  logic [INSTR_W-1:0] mem_d [PROG_DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Steps a downstream processor through a loaded program, one instruction per done
// handshake, with a watchdog that parks the sequencer in ERR on a lost done.
module instr_sequencer
  import seq_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic [LEN_W-1:0]   prog_len,
  input  logic               done,
  output logic [INSTR_W-1:0] instr_out,
  output logic               run,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               finished,
  output logic               error
);

  seq_state_e          state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    start_len;
  logic [INSTR_W-1:0]  mem_rdata;

  prog_mem u_prog_mem (
    .clk   (clk),
    .reset (reset),
    .we    (prog_we && !busy),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_q),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      wdog_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wdog_q  <= wdog_d;
      len_q   <= len_d;
    end
  end

  assign start_len = clamp_len(prog_len);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wdog_d  = wdog_q;
    len_d   = len_q;
    unique case (state_q)
      IDLE, ERR: begin
        if (start) begin
          len_d = start_len;
          if (start_len == '0) begin
            state_d = FIN;
          end else begin
            state_d = ISSUE;
            pc_d    = '0;
            wdog_d  = '0;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        wdog_d  = '0;
      end
      WAIT: begin
        // done is checked before the watchdog so a late done still counts.
        if (done) begin
          if ({1'b0, pc_q} == len_q - LEN_W'(1)) begin
            state_d = FIN;
          end else begin
            state_d = ISSUE;
            pc_d    = pc_q + PC_W'(1);
            wdog_d  = '0;
          end
        end else if (wdog_q == WDOG_W'(WDOG_MAX)) begin
          state_d = ERR;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    run       = (state_q == ISSUE);
    busy      = (state_q == ISSUE) || (state_q == WAIT);
    finished  = (state_q == FIN);
    error     = (state_q == ERR);
    pc        = pc_q;
    instr_out = mem_rdata;
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer with a small behavioural processor model.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic [4:0]  prog_len = '0;
  logic        done = 1'b0;
  logic [15:0] instr_out;
  logic        run;
  logic [3:0]  pc;
  logic        busy;
  logic        finished;
  logic        error;

  instr_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_len  (prog_len),
    .done      (done),
    .instr_out (instr_out),
    .run       (run),
    .pc        (pc),
    .busy      (busy),
    .finished  (finished),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] instr;
    logic [3:0]  pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mem_model [16];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          run_cnt = 0;
  int          resp_delay = 1;
  int          resp_cnt = 0;
  int          last_done_cyc = 0;
  int          fin_cyc = 0;
  int          prev_run_cyc = 0;
  bit          have_prev = 1'b0;
  bit          spacing_chk = 1'b0;
  int          exp_spacing = 0;
  logic [7:0]  r0 = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Processor model + scoreboard consumer, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (done) done = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        done = 1'b1;
        last_done_cyc = cyc;
      end
    end
    if (finished) fin_cyc = cyc;
    if (run) begin
      run_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_run", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("instr_out", {16'h0, instr_out}, {16'h0, e.instr});
        check_eq("run_pc", {28'h0, pc}, {28'h0, e.pc});
      end
      if (spacing_chk && have_prev) check_eq("run_spacing", cyc - prev_run_cyc, exp_spacing);
      prev_run_cyc = cyc;
      have_prev = 1'b1;
      case (instr_out[15:12])
        4'h2: r0 = instr_out[7:0];
        4'h6: r0 = r0 + instr_out[7:0];
        default: ;
      endcase
      if (resp_delay != 0) resp_cnt = resp_delay;
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_word(input logic [3:0] a, input logic [15:0] d);
    prog_we = 1'b1;
    prog_addr = a;
    prog_data = d;
    mem_model[a] = d;
    step(1);
    prog_we = 1'b0;
  endtask

  task automatic start_prog(input logic [4:0] len, input int npush);
    for (int i = 0; i < npush; i++) exp_q.push_back({mem_model[i], 4'(i)});
    have_prev = 1'b0;
    start = 1'b1;
    prog_len = len;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_finished(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (finished) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("finished_seen", {31'h0, seen}, 32'd1);
    step(1);
    check_eq("finished_one_cycle", {31'h0, finished}, 32'd0);
  endtask

  initial begin
    int base;
    bit found;
    for (int i = 0; i < 16; i++) mem_model[i] = '0;

    // Reset state
    step(2);
    reset = 1'b0;
    check_eq("rst_instr", {16'h0, instr_out}, 32'h0);
    check_eq("rst_run", {31'h0, run}, 32'd0);
    check_eq("rst_busy", {31'h0, busy}, 32'd0);
    check_eq("rst_pc", {28'h0, pc}, 32'd0);
    check_eq("rst_flags", {30'h0, finished, error}, 32'd0);

    // Two-instruction program with processor attached
    write_word(4'd0, 16'h2005);
    write_word(4'd1, 16'h6003);
    r0 = '0;
    resp_delay = 1;
    base = run_cnt;
    start_prog(5'd2, 2);
    wait_finished(100);
    check_eq("p2_runs", run_cnt - base, 32'd2);
    check_eq("p2_r0", {24'h0, r0}, 32'd8);
    check_eq("p2_sb_empty", exp_q.size(), 32'd0);

    // Four words, done 3 cycles after each run
    for (int i = 0; i < 4; i++) write_word(4'(i), 16'hA000 + 16'(i));
    resp_delay = 3;
    spacing_chk = 1'b1;
    exp_spacing = 4;
    base = run_cnt;
    start_prog(5'd4, 4);
    wait_finished(100);
    check_eq("p4_runs", run_cnt - base, 32'd4);
    check_eq("p4_fin_after_done", fin_cyc - last_done_cyc, 32'd1);
    check_eq("p4_pc_hold", {28'h0, pc}, 32'd3);

    // done arriving in the watchdog's last cycle beats the expiry
    resp_delay = 16;
    exp_spacing = 17;
    base = run_cnt;
    start_prog(5'd2, 2);
    wait_finished(200);
    spacing_chk = 1'b0;
    check_eq("late_done_runs", run_cnt - base, 32'd2);
    check_eq("late_done_noerr", {31'h0, error}, 32'd0);

    // Zero-length program
    base = run_cnt;
    start_prog(5'd0, 0);
    check_eq("len0_finished", {31'h0, finished}, 32'd1);
    check_eq("len0_busy", {31'h0, busy}, 32'd0);
    step(2);
    check_eq("len0_runs", run_cnt - base, 32'd0);

    // Over-length program clamps to the full memory
    for (int i = 0; i < 16; i++) write_word(4'(i), 16'($urandom));
    resp_delay = 1;
    base = run_cnt;
    start_prog(5'd20, 16);
    wait_finished(300);
    check_eq("len20_runs", run_cnt - base, 32'd16);
    check_eq("len20_sb_empty", exp_q.size(), 32'd0);

    // Lost done: watchdog expiry into ERR, then recovery by start
    resp_delay = 0;
    base = run_cnt;
    start_prog(5'd3, 1);
    step(16);
    check_eq("wd_last_wait_busy", {31'h0, busy}, 32'd1);
    check_eq("wd_last_wait_err", {31'h0, error}, 32'd0);
    step(1);
    check_eq("wd_error", {31'h0, error}, 32'd1);
    check_eq("wd_busy", {31'h0, busy}, 32'd0);
    check_eq("wd_run", {31'h0, run}, 32'd0);
    step(4);
    check_eq("wd_error_sticky", {31'h0, error}, 32'd1);
    check_eq("wd_runs", run_cnt - base, 32'd1);
    resp_delay = 1;
    start_prog(5'd1, 1);
    check_eq("recover_error_clr", {31'h0, error}, 32'd0);
    check_eq("recover_busy", {31'h0, busy}, 32'd1);
    wait_finished(100);

    // Write and start in the same cycle
    prog_we = 1'b1;
    prog_addr = 4'd0;
    prog_data = 16'h1234;
    mem_model[0] = 16'h1234;
    base = run_cnt;
    start_prog(5'd1, 1);
    prog_we = 1'b0;
    wait_finished(100);
    check_eq("wr_start_runs", run_cnt - base, 32'd1);

    // start and prog_we while busy are dropped
    write_word(4'd0, 16'h1111);
    write_word(4'd1, 16'h2222);
    resp_delay = 3;
    base = run_cnt;
    start_prog(5'd2, 2);
    step(2);
    prog_we = 1'b1;
    prog_addr = 4'd1;
    prog_data = 16'hFFFF;
    start = 1'b1;
    prog_len = 5'd5;
    step(1);
    prog_we = 1'b0;
    start = 1'b0;
    wait_finished(100);
    check_eq("busy_runs", run_cnt - base, 32'd2);
    check_eq("busy_readback", {16'h0, instr_out}, {16'h0, mem_model[1]});

    // Reset in WAIT of the second instruction
    for (int i = 0; i < 3; i++) write_word(4'(i), 16'hC0DE + 16'(i));
    start_prog(5'd3, 3);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (pc == 4'd1 && busy && !run) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("rst_mid_reached", {31'h0, found}, 32'd1);
    reset = 1'b1;
    step(1);
    resp_cnt = 0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) mem_model[i] = '0;
    base = run_cnt;
    check_eq("rst_mid_pc", {28'h0, pc}, 32'd0);
    check_eq("rst_mid_run", {31'h0, run}, 32'd0);
    check_eq("rst_mid_busy", {31'h0, busy}, 32'd0);
    check_eq("rst_mid_error", {31'h0, error}, 32'd0);
    check_eq("rst_mid_mem", {16'h0, instr_out}, 32'h0);
    reset = 1'b0;
    step(8);
    check_eq("rst_mid_no_restart", run_cnt - base, 32'd0);
    check_eq("rst_mid_idle", {31'h0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
